nap_session_ctrl: RTL
=====================

# nap_session_ctrl

Parametrised nap-session controller, the next-generation core of the nap machine. It holds a BCD HH:MM:SS nap duration, counts it down at a derived 1 Hz tick, and raises an alarm request. Alarm is cancellable or snoozable up to a configured number of times, and auto-times-out. It sits between the setting blocks (auto/manual time entry) and the sound/light/display blocks. It replaces the separate mode FSM and countdown-register pairing with one block.

## Interface
- TICK_DIV, 1000000, clock cycles per 1 s tick (≥2)
- ALARM_TIMEOUT_S, 60, seconds the alarm rings before auto-completion (1–255)
- SNOOZE_MIN, 5, minutes reloaded per snooze (1–59)
- MAX_SNOOZE, 3, snoozes allowed per session (1–15)
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load_valid  in  1  one-cycle pulse: capture load_time
- load_time  in  24  BCD {H10,H1,M10,M1,S10,S1}
- start  in  1  pulse: begin sleep (sharp key)
- cancel  in  1  pulse: abort session / silence alarm
- snooze  in  1  pulse: snooze during alarm
- remain  out  24  current remaining time, BCD
- state  out  3  IDLE=0, ARMED=1, SLEEP=2, ALARM=3, DONE=4
- sleeping  out  1  high in SLEEP (lullaby enable)
- alarm_on  out  1  high in ALARM (piezo/light enable)
- load_err  out  1  one-cycle pulse on rejected load
- snooze_left  out  4  snoozes remaining
- tick  out  1  one-cycle 1 Hz pulse (SLEEP/ALARM only)

## Operation
- Reset: state IDLE, remain 0, all flags 0, snooze_left 0, tick counter 0.
- Load validity: every digit ≤9, M10 ≤5, S10 ≤5, hours ≤23, value ≠ 00:00:00. Valid load in IDLE/ARMED/DONE → remain=load_time, snooze_left=MAX_SNOOZE, state ARMED. Invalid load → load_err pulse, no other change. Loads in SLEEP/ALARM are ignored with no load_err.
- ARMED + start → SLEEP, tick counter cleared.
- SLEEP: each tick decrements remain by 1 s with BCD borrow (S1 9→… wrap 0→9, S10 0→5, M1, M10 0→5, H1, H10). A tick at remain=00:00:01 → remain 0, state ALARM, alarm-second counter cleared.
- ALARM: counts ticks; at ALARM_TIMEOUT_S ticks → DONE.
- ALARM + snooze with snooze_left>0 → remain=00:SNOOZE_MIN:00 (BCD), snooze_left−1, state SLEEP, tick counter cleared. With snooze_left=0, snooze is ignored.
- cancel: SLEEP or ALARM → DONE, remain held. ARMED → IDLE, remain 0. IDLE/DONE: no effect.
- DONE + start → IDLE (acknowledge).
- Same-cycle priority: reset > cancel > load_valid > snooze > start > tick expiry.

## Timing
- All outputs are registered. A state change is visible the cycle after the triggering input.
- Tick counter runs 0..TICK_DIV−1 only in SLEEP/ALARM. tick is high the cycle the count is TICK_DIV−1. The first tick occurs TICK_DIV cycles after entering SLEEP.
- The remain update and the SLEEP→ALARM transition occur on the same edge as the tick.
- Input pulses are level-sampled each cycle. A held start re-triggers only where it is legal: ARMED→SLEEP, then ignored in SLEEP.
- Reset mid-session returns every output to its reset value on the next edge.

## Configuration
- NAP_SNOOZE_EN defined: snooze behaviour as above.
- NAP_SNOOZE_EN undefined: snooze input ignored, snooze_left tied to 0, and no snooze logic is synthesised. All other behaviour is identical.

## Test plan
- TICK_DIV=4. Load 00:00:03, start → SLEEP, tick every 4 cycles, remain 02→01→00, then ALARM on the 3rd tick edge with alarm_on=1.
- Borrow chain: load 10:00:00, start, one tick → remain 09:59:59. Load 00:59:60 → load_err pulse, state unchanged.
- Snooze (NAP_SNOOZE_EN, MAX_SNOOZE=1, SNOOZE_MIN=5): reach ALARM, snooze → remain 00:05:00, snooze_left 0, SLEEP. Next ALARM, snooze ignored.
- ALARM_TIMEOUT_S=3: reach ALARM, no input → DONE after 3 ticks. Then start → IDLE.
- Same cycle cancel+snooze in ALARM → DONE, snooze_left unchanged. Cancel in ARMED → IDLE, remain 0.
- Reset asserted in SLEEP at remain 00:00:02 → next cycle state 0, remain 0, tick 0, sleeping 0.

Source files
------------

// File: rtl/nap_session_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | nap_session_ctrl: BCD nap countdown, alarm, snooze (NAP_SNOOZE_EN)      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module nap_session_ctrl #(
   parameter int TICK_DIV        = 1000000,
   parameter int ALARM_TIMEOUT_S = 60,
   parameter int SNOOZE_MIN      = 5,
   parameter int MAX_SNOOZE      = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [23:0] load_time,
   input  logic        start,
   input  logic        cancel,
   input  logic        snooze,
   output logic [23:0] remain,
   output logic [2:0]  state,
   output logic        sleeping,
   output logic        alarm_on,
   output logic        load_err,
   output logic [3:0]  snooze_left,
   output logic        tick
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_SLEEP = 3'd2,
      ST_ALARM = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int          c_CNT_W       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_TICK_LAST = c_CNT_W'(TICK_DIV - 1);
   localparam logic [7:0]  c_ALARM_LAST  = 8'(ALARM_TIMEOUT_S - 1);
   localparam logic [23:0] c_SNOOZE_TIME = {8'h00, 4'(SNOOZE_MIN / 10), 4'(SNOOZE_MIN % 10), 8'h00};

   state_t               r_state, w_state_nxt;
   logic [23:0]          r_remain, w_remain_nxt;
   logic [c_CNT_W-1:0]   r_tick_cnt, w_tick_cnt_nxt;
   logic [7:0]           r_alarm_sec, w_alarm_sec_nxt;
   logic                 r_sleeping, r_alarm_on, r_load_err;
   logic                 w_load_err_nxt, w_active, w_tick, w_restart;
   logic                 w_load_take, w_snz_take, w_snooze_go;

   // One-second BCD decrement; digits S10 and M10 wrap to 5, the others to 9.
   function automatic logic [23:0] bcd_dec(input logic [23:0] t);
      logic [23:0] r;
      logic        borrow;
      logic [3:0]  lim;
      r      = t;
      borrow = 1'b1;
      for (int i = 0; i < 6; i++) begin
         lim = (i == 1 || i == 3) ? 4'd5 : 4'd9;
         if (borrow) begin
            if (r[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = lim;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic load_ok(input logic [23:0] t);
      logic ok;
      ok = (t != 24'h0);
      for (int i = 0; i < 6; i++) begin
         if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
      end
      if (t[15:12] > 4'd5 || t[7:4] > 4'd5) ok = 1'b0;
      if (t[23:20] > 4'd2 || (t[23:20] == 4'd2 && t[19:16] > 4'd3)) ok = 1'b0;
      return ok;
   endfunction

   assign w_active = (r_state == ST_SLEEP) || (r_state == ST_ALARM);
   assign w_tick   = w_active && (r_tick_cnt == c_TICK_LAST);

`ifdef NAP_SNOOZE_EN
   logic [3:0] r_snooze_left;

   assign w_snooze_go = snooze && (r_state == ST_ALARM) && (r_snooze_left != 4'd0);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_snooze_left <= 4'd0;
      end else if (w_load_take) begin
         r_snooze_left <= 4'(MAX_SNOOZE);
      end else if (w_snz_take) begin
         r_snooze_left <= r_snooze_left - 4'd1;
      end
   end

   assign snooze_left = r_snooze_left;
`else
   logic w_unused_snooze;

   assign w_snooze_go     = 1'b0;
   assign w_unused_snooze = ^{snooze, w_load_take, w_snz_take, (MAX_SNOOZE == 0)};
   assign snooze_left     = 4'd0;
`endif

   // Priority chain: cancel > load > snooze > start > tick expiry.
   // A request that is illegal in the current state falls through.
   always_comb begin
      w_state_nxt     = r_state;
      w_remain_nxt    = r_remain;
      w_alarm_sec_nxt = r_alarm_sec;
      w_load_err_nxt  = 1'b0;
      w_restart       = 1'b0;
      w_load_take     = 1'b0;
      w_snz_take      = 1'b0;
      if (cancel && (r_state == ST_ARMED || w_active)) begin
         if (r_state == ST_ARMED) begin
            w_state_nxt  = ST_IDLE;
            w_remain_nxt = 24'h0;
         end else begin
            w_state_nxt  = ST_DONE;
         end
      end else if (load_valid && !w_active) begin
         if (load_ok(load_time)) begin
            w_remain_nxt = load_time;
            w_state_nxt  = ST_ARMED;
            w_load_take  = 1'b1;
         end else begin
            w_load_err_nxt = 1'b1;
         end
      end else if (w_snooze_go) begin
         w_remain_nxt = c_SNOOZE_TIME;
         w_state_nxt  = ST_SLEEP;
         w_restart    = 1'b1;
         w_snz_take   = 1'b1;
      end else if (start && r_state == ST_ARMED) begin
         w_state_nxt = ST_SLEEP;
         w_restart   = 1'b1;
      end else if (start && r_state == ST_DONE) begin
         w_state_nxt = ST_IDLE;
      end else if (w_tick && r_state == ST_SLEEP) begin
         if (r_remain == 24'h000001) begin
            w_remain_nxt    = 24'h0;
            w_state_nxt     = ST_ALARM;
            w_alarm_sec_nxt = 8'd0;
         end else begin
            w_remain_nxt = bcd_dec(r_remain);
         end
      end else if (w_tick && r_state == ST_ALARM) begin
         if (r_alarm_sec == c_ALARM_LAST) w_state_nxt = ST_DONE;
         else                              w_alarm_sec_nxt = r_alarm_sec + 8'd1;
      end

      if (w_restart || w_tick || !(w_state_nxt == ST_SLEEP || w_state_nxt == ST_ALARM))
         w_tick_cnt_nxt = '0;
      else
         w_tick_cnt_nxt = r_tick_cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_remain    <= 24'h0;
         r_tick_cnt  <= '0;
         r_alarm_sec <= 8'd0;
         r_sleeping  <= 1'b0;
         r_alarm_on  <= 1'b0;
         r_load_err  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_remain    <= w_remain_nxt;
         r_tick_cnt  <= w_tick_cnt_nxt;
         r_alarm_sec <= w_alarm_sec_nxt;
         r_sleeping  <= (w_state_nxt == ST_SLEEP);
         r_alarm_on  <= (w_state_nxt == ST_ALARM);
         r_load_err  <= w_load_err_nxt;
      end
   end

   assign remain   = r_remain;
   assign state    = r_state;
   assign sleeping = r_sleeping;
   assign alarm_on = r_alarm_on;
   assign load_err = r_load_err;
   assign tick     = w_tick;

endmodule
`default_nettype wire
